// File: rtl/ntt_pkg.sv
// Shared constants and FSM state type for the NTT sequencing controller.
package ntt_pkg;
    localparam int NTT_N    = 256;
    localparam int NTT_LOGN = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } ntt_state_t;
endpackage

// File: rtl/ntt_addr_gen.sv
// Butterfly pair address and twiddle index generation, purely combinational
// from stage, pair counter and transform direction.
module ntt_addr_gen
    import ntt_pkg::*;
#(
    parameter int N    = NTT_N,
    parameter int LOGN = NTT_LOGN
) (
    input  logic [LOGN-1:0] i_stage,
    input  logic [LOGN-2:0] i_pair,
    input  logic            i_mode,
    output logic [LOGN-1:0] o_addr_a,
    output logic [LOGN-1:0] o_addr_b,
    output logic [LOGN-1:0] o_tw_idx
);
    localparam logic [LOGN-1:0] K_MAX = LOGN'(LOGN - 1);
    localparam logic [LOGN-1:0] HALF  = LOGN'(N / 2);
    localparam logic [LOGN-1:0] ONE   = LOGN'(1);

    logic [LOGN-1:0] w_k;
    logic [LOGN-1:0] w_p;
    logic [LOGN-1:0] w_span;
    logic [LOGN-1:0] w_lo_mask;
    logic [LOGN-1:0] w_group;
    logic [LOGN-1:0] w_addr_a;

    // Span is (N/2)>>s going forward and 1<<s going inverse; w_k = log2(span).
    assign w_k       = i_mode ? i_stage : (K_MAX - i_stage);
    assign w_p       = {1'b0, i_pair};
    assign w_span    = ONE << w_k;
    assign w_lo_mask = w_span - ONE;
    assign w_group   = w_p >> w_k;
    // Insert a zero bit at position w_k: group bits move up one, low bits stay.
    assign w_addr_a  = ((w_group << 1) << w_k) | (w_p & w_lo_mask);

    assign o_addr_a = w_addr_a;
    assign o_addr_b = w_addr_a + w_span;
    assign o_tw_idx = (i_mode ? (HALF >> i_stage) : (ONE << i_stage)) + w_group;
endmodule

// File: rtl/ntt_seq_ctrl.sv
// Stage/pair sequencer for an in-place NTT/INTT: issues BRAM reads, drains the
// butterfly pipeline between stages and replays the addresses as writes.
module ntt_seq_ctrl
    import ntt_pkg::*;
#(
    parameter int N      = NTT_N,
    parameter int LOGN   = NTT_LOGN,
    parameter int RD_LAT = 1,
    parameter int BF_LAT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            mode,
    output logic            busy,
    output logic            done,
    output logic            rd_en,
    output logic [LOGN-1:0] rd_addr_a,
    output logic [LOGN-1:0] rd_addr_b,
    output logic [LOGN-1:0] tw_idx,
    output logic            bf_mode,
    output logic            bf_scale,
    output logic            wr_en,
    output logic [LOGN-1:0] wr_addr_a,
    output logic [LOGN-1:0] wr_addr_b,
    output ntt_state_t      dbg_state
);
    localparam int              D       = RD_LAT + BF_LAT;
    localparam int              DLW     = 2 * LOGN + 1;
    localparam logic [LOGN-2:0] P_LAST  = (LOGN-1)'(N / 2 - 1);
    localparam logic [LOGN-1:0] S_LAST  = LOGN'(LOGN - 1);
    localparam logic [7:0]      DR_LAST = 8'(D - 1);

    ntt_state_t      r_state;
    ntt_state_t      w_next;
    logic [LOGN-1:0] r_stage;
    logic [LOGN-2:0] r_pair;
    logic [7:0]      r_drain;
    logic            r_mode;
    logic [DLW-1:0]  r_dl [D];

    logic            w_run;
    logic [LOGN-1:0] w_addr_a;
    logic [LOGN-1:0] w_addr_b;
    logic [LOGN-1:0] w_tw;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_next = ST_RUN;
            ST_RUN:   if (r_pair == P_LAST) w_next = ST_DRAIN;
            ST_DRAIN: if (r_drain == DR_LAST) w_next = (r_stage == S_LAST) ? ST_DONE : ST_RUN;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Pair counter wraps to zero on its own after N/2 issues.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stage <= '0;
            r_pair  <= '0;
            r_drain <= '0;
            r_mode  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_stage <= '0;
                        r_pair  <= '0;
                        r_drain <= '0;
                        r_mode  <= mode;
                    end
                end
                ST_RUN: r_pair <= r_pair + 1'b1;
                ST_DRAIN: begin
                    if (r_drain == DR_LAST) begin
                        r_drain <= '0;
                        if (r_stage != S_LAST) r_stage <= r_stage + 1'b1;
                    end else begin
                        r_drain <= r_drain + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    ntt_addr_gen #(
        .N    (N),
        .LOGN (LOGN)
    ) u_addr_gen (
        .i_stage  (r_stage),
        .i_pair   (r_pair),
        .i_mode   (r_mode),
        .o_addr_a (w_addr_a),
        .o_addr_b (w_addr_b),
        .o_tw_idx (w_tw)
    );

    assign w_run     = (r_state == ST_RUN);
    assign rd_en     = w_run;
    assign rd_addr_a = w_run ? w_addr_a : '0;
    assign rd_addr_b = w_run ? w_addr_b : '0;
    assign tw_idx    = w_run ? w_tw : '0;
    assign bf_scale  = w_run & r_mode & (r_stage == S_LAST);
    assign bf_mode   = r_mode;
    assign busy      = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign done      = (r_state == ST_DONE);
    assign dbg_state = r_state;

    // Read strobe and addresses (already zero when idle) replayed D cycles later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < D; i++) r_dl[i] <= '0;
        end else begin
            r_dl[0] <= {rd_en, rd_addr_a, rd_addr_b};
            for (int i = 1; i < D; i++) r_dl[i] <= r_dl[i-1];
        end
    end

    assign wr_en     = r_dl[D-1][DLW-1];
    assign wr_addr_a = r_dl[D-1][2*LOGN-1:LOGN];
    assign wr_addr_b = r_dl[D-1][LOGN-1:0];
endmodule

// File: tb/tb_ntt_seq_ctrl.sv
// Self-checking bench for ntt_seq_ctrl at default parameters: model-driven
// read/write scoreboard, spot-value table and multi-cycle corner sequences.
module tb_ntt_seq_ctrl;
    import ntt_pkg::*;

    localparam int LOGN   = 8;
    localparam int HALF   = 128;
    localparam int D      = 5;
    localparam int T_DONE = LOGN * (HALF + D) + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       mode = 1'b0;
    logic       busy, done, rd_en, bf_mode, bf_scale, wr_en;
    logic [7:0] rd_addr_a, rd_addr_b, tw_idx, wr_addr_a, wr_addr_b;
    ntt_state_t dbg_state;

    ntt_seq_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .busy      (busy),
        .done      (done),
        .rd_en     (rd_en),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .tw_idx    (tw_idx),
        .bf_mode   (bf_mode),
        .bf_scale  (bf_scale),
        .wr_en     (wr_en),
        .wr_addr_a (wr_addr_a),
        .wr_addr_b (wr_addr_b),
        .dbg_state (dbg_state)
    );

    // Clock / cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; logic [7:0] a; logic [7:0] b; logic [7:0] tw; logic sc; logic md; } rd_t;
    typedef struct { int cyc; logic [7:0] a; logic [7:0] b; } wr_t;
    typedef struct { logic md; int st; int p; logic [7:0] a; logic [7:0] b; logic [7:0] tw; logic sc; } vec_t;

    rd_t rd_q[$];
    wr_t wr_q[$];
    int  checks = 0;
    int  errors = 0;
    int  rd_cnt = 0;
    int  wr_cnt = 0;
    int  sc_cnt = 0;
    logic [7:0] obs_a  [1024];
    logic [7:0] obs_b  [1024];
    logic [7:0] obs_tw [1024];
    logic       obs_sc [1024];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference schedule: arithmetic form of span, group and twiddle.
    task automatic push_model(input logic md, input int t0);
        rd_t e;
        int  l, g;
        for (int st = 0; st < LOGN; st++) begin
            for (int p = 0; p < HALF; p++) begin
                l = md ? (1 << st) : (HALF >> st);
                g = p / l;
                e.cyc = t0 + 1 + st * (HALF + D) + p;
                e.a   = 8'(g * 2 * l + p % l);
                e.b   = 8'(g * 2 * l + p % l + l);
                e.tw  = md ? 8'((HALF >> st) + g) : 8'((1 << st) + g);
                e.sc  = md && (st == LOGN - 1);
                e.md  = md;
                rd_q.push_back(e);
            end
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        rd_t e;
        wr_t w;
        if (rst) begin
            if (rd_en) begin
                if (rd_q.size() == 0) begin
                    check("unexpected_read", 1, 0);
                end else begin
                    e = rd_q.pop_front();
                    check("rd_cycle", cyc, e.cyc);
                    check("rd_fields", {rd_addr_a, rd_addr_b, tw_idx, bf_scale, bf_mode},
                          {e.a, e.b, e.tw, e.sc, e.md});
                    w.cyc = e.cyc + D;
                    w.a   = e.a;
                    w.b   = e.b;
                    wr_q.push_back(w);
                end
                if (rd_cnt < 1024) begin
                    obs_a[rd_cnt]  = rd_addr_a;
                    obs_b[rd_cnt]  = rd_addr_b;
                    obs_tw[rd_cnt] = tw_idx;
                    obs_sc[rd_cnt] = bf_scale;
                end
                rd_cnt++;
                if (bf_scale) sc_cnt++;
            end else begin
                check("rd_idle_zero", {rd_addr_a, rd_addr_b, tw_idx, bf_scale}, 0);
            end
            if (wr_en) begin
                if (wr_q.size() == 0) begin
                    check("unexpected_write", 1, 0);
                end else begin
                    w = wr_q.pop_front();
                    check("wr_cycle", cyc, w.cyc);
                    check("wr_addr", {wr_addr_a, wr_addr_b}, {w.a, w.b});
                end
                wr_cnt++;
            end else begin
                check("wr_idle_zero", {wr_addr_a, wr_addr_b}, 0);
            end
        end
    end

    // Driver tasks
    task automatic do_start(input logic md, output int t0);
        @(posedge clk);
        #1;
        mode  = md;
        start = 1'b1;
        t0    = cyc;
        rd_cnt = 0;
        wr_cnt = 0;
        sc_cnt = 0;
        push_model(md, t0);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_start", busy, 1);
    endtask

    task automatic wait_done(input int t_exp, input string nm, input bit expect_empty);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 3000);
        if (!done) begin
            check({nm, "_timeout"}, 0, 1);
        end else begin
            check({nm, "_done_cycle"}, cyc, t_exp);
            check({nm, "_busy_low_at_done"}, busy, 0);
            if (expect_empty) begin
                check({nm, "_reads_left"}, rd_q.size(), 0);
                check({nm, "_writes_left"}, wr_q.size(), 0);
            end
        end
    endtask

    task automatic check_table(input logic md, input vec_t tbl[10]);
        int idx;
        for (int i = 0; i < 10; i++) begin
            if (tbl[i].md == md) begin
                idx = tbl[i].st * HALF + tbl[i].p;
                check($sformatf("table_m%0d_s%0d_p%0d", md, tbl[i].st, tbl[i].p),
                      {obs_a[idx], obs_b[idx], obs_tw[idx], obs_sc[idx]},
                      {tbl[i].a, tbl[i].b, tbl[i].tw, tbl[i].sc});
            end
        end
    endtask

    initial begin
        vec_t tbl[10];
        int   t0, t1, n, wr_before;

        tbl[0] = '{1'b0, 0, 0,   8'd0,   8'd128, 8'd1,   1'b0};
        tbl[1] = '{1'b0, 0, 127, 8'd127, 8'd255, 8'd1,   1'b0};
        tbl[2] = '{1'b0, 7, 0,   8'd0,   8'd1,   8'd128, 1'b0};
        tbl[3] = '{1'b0, 7, 1,   8'd2,   8'd3,   8'd129, 1'b0};
        tbl[4] = '{1'b0, 3, 40,  8'd72,  8'd88,  8'd10,  1'b0};
        tbl[5] = '{1'b1, 0, 0,   8'd0,   8'd1,   8'd128, 1'b0};
        tbl[6] = '{1'b1, 0, 1,   8'd2,   8'd3,   8'd129, 1'b0};
        tbl[7] = '{1'b1, 7, 0,   8'd0,   8'd128, 8'd1,   1'b1};
        tbl[8] = '{1'b1, 7, 127, 8'd127, 8'd255, 8'd1,   1'b1};
        tbl[9] = '{1'b1, 3, 40,  8'd80,  8'd88,  8'd21,  1'b0};

        // Reset state
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_strobes", {rd_en, wr_en, bf_scale, bf_mode}, 0);
        check("rst_addrs", {rd_addr_a, rd_addr_b, tw_idx, wr_addr_a, wr_addr_b}, 0);
        check("rst_state", dbg_state, ST_IDLE);
        rst = 1'b1;
        repeat (2) @(posedge clk);

        // Forward NTT
        do_start(1'b0, t0);
        wait_done(t0 + T_DONE, "ntt", 1'b1);
        check("ntt_write_count", wr_cnt, 1024);
        check("ntt_scale_count", sc_cnt, 0);
        check_table(1'b0, tbl);
        @(negedge clk);
        check("ntt_done_one_cycle", done, 0);

        // Inverse INTT
        do_start(1'b1, t0);
        wait_done(t0 + T_DONE, "intt", 1'b1);
        check("intt_write_count", wr_cnt, 1024);
        check("intt_scale_count", sc_cnt, 128);
        check_table(1'b1, tbl);

        // Start re-asserted and mode toggled while busy
        do_start(1'b0, t0);
        for (int k = 0; k < 800; k++) begin
            @(posedge clk);
            #1;
            if (k % 37 == 0) mode = ~mode;
            start = (k >= 300 && k < 310) || (k >= 700 && k < 705);
        end
        mode  = 1'b0;
        start = 1'b0;
        wait_done(t0 + T_DONE, "disturb", 1'b1);
        check("disturb_write_count", wr_cnt, 1024);

        // Reset in the middle of stage 3, pair 40
        do_start(1'b1, t0);
        n = 0;
        while (rd_cnt < 3 * HALF + 41 && n < 2000) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("abort_reached_point", rd_cnt, 3 * HALF + 41);
        rst = 1'b0;
        #1;
        check("abort_busy_done", {busy, done}, 0);
        check("abort_strobes", {rd_en, wr_en, bf_scale, bf_mode}, 0);
        check("abort_addrs", {rd_addr_a, rd_addr_b, tw_idx, wr_addr_a, wr_addr_b}, 0);
        rd_q.delete();
        wr_q.delete();
        wr_before = wr_cnt;
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b1;
        repeat (20) @(posedge clk);
        check("abort_no_writes", wr_cnt, wr_before);
        do_start(1'b0, t0);
        wait_done(t0 + T_DONE, "after_abort", 1'b1);
        check("after_abort_write_count", wr_cnt, 1024);
        check_table(1'b0, tbl);

        // Back-to-back: start held high across DONE
        do_start(1'b0, t0);
        start = 1'b1;
        mode  = 1'b1;
        wait_done(t0 + T_DONE, "b2b_first", 1'b1);
        t1 = t0 + T_DONE + 1;
        rd_cnt = 0;
        sc_cnt = 0;
        push_model(1'b1, t1);
        @(posedge clk);
        @(posedge clk);
        #1;
        start = 1'b0;
        mode  = 1'b0;
        check("b2b_second_busy", busy, 1);
        check("b2b_first_read", rd_en, 1);
        wait_done(t1 + T_DONE, "b2b_second", 1'b1);
        check("b2b_second_scale_count", sc_cnt, 128);
        check_table(1'b1, tbl);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end
endmodule
